// File: rtl/ex_branch_pipe_pkg.sv
// Shared branch micro-op codes and the decode helper used by the branch pipe.
// Op codes match the core-wide op defines; JAL/JALR live here alongside the conditionals.
package ex_branch_pipe_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int OP_WIDTH_DEF   = 6;
    localparam int TAG_WIDTH_DEF  = 4;
    localparam int DEPTH_DEF      = 4;
    localparam int CNT_WIDTH_DEF  = 32;

    localparam logic [5:0] OP_BEQ  = 6'h10;
    localparam logic [5:0] OP_BNE  = 6'h11;
    localparam logic [5:0] OP_BLT  = 6'h12;
    localparam logic [5:0] OP_BGE  = 6'h13;
    localparam logic [5:0] OP_BLTU = 6'h14;
    localparam logic [5:0] OP_BGEU = 6'h15;
    localparam logic [5:0] OP_JAL  = 6'h16;
    localparam logic [5:0] OP_JALR = 6'h17;

    typedef enum logic [3:0] {
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU,
        BR_JAL,
        BR_JALR,
        BR_NONE
    } br_kind_e;

    // Ops wider than the shared 6-bit codes are zero-extended into 8 bits by the caller.
    function automatic br_kind_e decode_op(input logic [7:0] op);
        br_kind_e kind;
        case (op)
            {2'b00, OP_BEQ}:  kind = BR_EQ;
            {2'b00, OP_BNE}:  kind = BR_NE;
            {2'b00, OP_BLT}:  kind = BR_LT;
            {2'b00, OP_BGE}:  kind = BR_GE;
            {2'b00, OP_BLTU}: kind = BR_LTU;
            {2'b00, OP_BGEU}: kind = BR_GEU;
            {2'b00, OP_JAL}:  kind = BR_JAL;
            {2'b00, OP_JALR}: kind = BR_JALR;
            default:          kind = BR_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/ex_branch_pipe_fifo_sync.sv
// Small synchronous FIFO with clear; head is read combinationally so a queued
// entry can reach the output register on the very next edge.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Callers never push when full or pop when empty; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/ex_branch_pipe.sv
// Buffered branch/jump resolver: FIFO of micro-ops, inline resolver, registered
// result with backpressure, flush, and consumed/mispredict counters.
module ex_branch_pipe
    import ex_branch_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int OP_WIDTH   = 6,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_WIDTH-1:0]      in_op,
    input  logic [DATA_WIDTH-1:0]    in_src1,
    input  logic [DATA_WIDTH-1:0]    in_src2,
    input  logic [ADDR_WIDTH-1:0]    in_pc,
    input  logic [DATA_WIDTH-1:0]    in_offset,
    input  logic [ADDR_WIDTH-1:0]    in_pred_pc,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     out_wb,
    output logic [DATA_WIDTH-1:0]    out_link,
    output logic                     out_taken,
    output logic [ADDR_WIDTH-1:0]    out_next_pc,
    output logic                     out_mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_WIDTH-1:0]     branch_cnt,
    output logic [CNT_WIDTH-1:0]     mispredict_cnt
);

    localparam int EW = OP_WIDTH + 3 * DATA_WIDTH + 2 * ADDR_WIDTH + TAG_WIDTH;

    logic [EW-1:0]         fifo_wdata;
    logic [EW-1:0]         fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;

    logic [OP_WIDTH-1:0]   h_op;
    logic [DATA_WIDTH-1:0] h_src1;
    logic [DATA_WIDTH-1:0] h_src2;
    logic [ADDR_WIDTH-1:0] h_pc;
    logic [DATA_WIDTH-1:0] h_offset;
    logic [ADDR_WIDTH-1:0] h_pred_pc;
    logic [TAG_WIDTH-1:0]  h_tag;

    logic                  out_valid_reg;
    logic [TAG_WIDTH-1:0]  out_tag_reg;
    logic                  out_wb_reg;
    logic [DATA_WIDTH-1:0] out_link_reg;
    logic                  out_taken_reg;
    logic [ADDR_WIDTH-1:0] out_next_pc_reg;
    logic                  out_mispredict_reg;
    logic [CNT_WIDTH-1:0]  branch_cnt_reg;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_reg;

    br_kind_e              kind;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] br_target;
    logic [ADDR_WIDTH-1:0] jalr_target;
    logic [ADDR_WIDTH-1:0] res_target;
    logic [ADDR_WIDTH-1:0] res_next_pc;
    logic [DATA_WIDTH-1:0] res_link;
    logic                  res_taken;
    logic                  res_wb;
    logic                  res_mispredict;
    logic                  out_fire;

    assign out_fire   = out_valid_reg && out_ready;
    assign fifo_push  = in_valid && in_ready && !flush;
    assign fifo_pop   = !fifo_empty && (!out_valid_reg || out_ready) && !flush;
    assign in_ready   = !fifo_full;
    assign fifo_wdata = {in_op, in_src1, in_src2, in_pc, in_offset, in_pred_pc, in_tag};
    assign {h_op, h_src1, h_src2, h_pc, h_offset, h_pred_pc, h_tag} = fifo_rdata;

    fifo_sync #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (occupancy),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Resolver works on the FIFO head; all PC math wraps at ADDR_WIDTH.
    always_comb begin
        kind        = decode_op(8'(h_op));
        pc_plus4    = h_pc + ADDR_WIDTH'(4);
        br_target   = h_pc + h_offset[ADDR_WIDTH-1:0];
        jalr_target = (h_src1[ADDR_WIDTH-1:0] + h_offset[ADDR_WIDTH-1:0])
                      & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
        res_taken   = 1'b0;
        res_wb      = 1'b0;
        res_target  = br_target;
        case (kind)
            BR_EQ:   res_taken = (h_src1 == h_src2);
            BR_NE:   res_taken = (h_src1 != h_src2);
            BR_LT:   res_taken = ($signed(h_src1) <  $signed(h_src2));
            BR_GE:   res_taken = ($signed(h_src1) >= $signed(h_src2));
            BR_LTU:  res_taken = (h_src1 <  h_src2);
            BR_GEU:  res_taken = (h_src1 >= h_src2);
            BR_JAL: begin
                res_taken = 1'b1;
                res_wb    = 1'b1;
            end
            BR_JALR: begin
                res_taken  = 1'b1;
                res_wb     = 1'b1;
                res_target = jalr_target;
            end
            default: begin
                res_taken = 1'b0;
                res_wb    = 1'b0;
            end
        endcase
        res_next_pc    = res_taken ? res_target : pc_plus4;
        res_link       = res_wb ? DATA_WIDTH'(pc_plus4) : '0;
        res_mispredict = (res_next_pc != h_pred_pc);
    end

    // Flush wins over load; clearing the payload too keeps idle outputs quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg      <= 1'b0;
            out_tag_reg        <= '0;
            out_wb_reg         <= 1'b0;
            out_link_reg       <= '0;
            out_taken_reg      <= 1'b0;
            out_next_pc_reg    <= '0;
            out_mispredict_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg      <= 1'b0;
            out_tag_reg        <= '0;
            out_wb_reg         <= 1'b0;
            out_link_reg       <= '0;
            out_taken_reg      <= 1'b0;
            out_next_pc_reg    <= '0;
            out_mispredict_reg <= 1'b0;
        end else if (fifo_pop) begin
            out_valid_reg      <= 1'b1;
            out_tag_reg        <= h_tag;
            out_wb_reg         <= res_wb;
            out_link_reg       <= res_link;
            out_taken_reg      <= res_taken;
            out_next_pc_reg    <= res_next_pc;
            out_mispredict_reg <= res_mispredict;
        end else if (out_fire) begin
            out_valid_reg      <= 1'b0;
        end
    end

    // Counters observe the handshake even in a flush cycle and are never cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_reg     <= '0;
            mispredict_cnt_reg <= '0;
        end else if (out_fire) begin
            branch_cnt_reg <= branch_cnt_reg + 1'b1;
            if (out_mispredict_reg) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_tag        = out_tag_reg;
    assign out_wb         = out_wb_reg;
    assign out_link       = out_link_reg;
    assign out_taken      = out_taken_reg;
    assign out_next_pc    = out_next_pc_reg;
    assign out_mispredict = out_mispredict_reg;
    assign branch_cnt     = branch_cnt_reg;
    assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_ex_branch_pipe.sv
// Bench for ex_branch_pipe: directed scenarios then random traffic, checked every
// cycle against a queue-based model of accepted-but-unconsumed results.
module tb_ex_branch_pipe;
    import ex_branch_pipe_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  tag;
        logic        wb;
        logic [31:0] link;
        logic        taken;
        logic [31:0] next;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] in_pc;
    logic [31:0] in_offset;
    logic [31:0] in_pred_pc;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tag;
    logic        out_wb;
    logic [31:0] out_link;
    logic        out_taken;
    logic [31:0] out_next_pc;
    logic        out_mispredict;
    logic [2:0]  occupancy;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    bit          m_ov;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    logic [5:0]  ops [9] = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, 6'h3F};

    ex_branch_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_src1        (in_src1),
        .in_src2        (in_src2),
        .in_pc          (in_pc),
        .in_offset      (in_offset),
        .in_pred_pc     (in_pred_pc),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tag        (out_tag),
        .out_wb         (out_wb),
        .out_link       (out_link),
        .out_taken      (out_taken),
        .out_next_pc    (out_next_pc),
        .out_mispredict (out_mispredict),
        .occupancy      (occupancy),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_resolve(logic [5:0] op, logic [31:0] s1, logic [31:0] s2,
                                           logic [31:0] pc, logic [31:0] off, logic [31:0] pred,
                                           logic [3:0] tag);
        exp_t e;
        bit   t;
        bit   w;
        t = 0;
        w = 0;
        case (op)
            OP_BEQ:  t = (s1 == s2);
            OP_BNE:  t = (s1 != s2);
            OP_BLT:  t = ($signed(s1) < $signed(s2));
            OP_BGE:  t = ($signed(s1) >= $signed(s2));
            OP_BLTU: t = (s1 < s2);
            OP_BGEU: t = (s1 >= s2);
            OP_JAL:  begin t = 1; w = 1; end
            OP_JALR: begin t = 1; w = 1; end
            default: begin t = 0; w = 0; end
        endcase
        e.tag   = tag;
        e.wb    = w;
        e.taken = t;
        e.link  = w ? pc + 32'd4 : 32'd0;
        if (!t)
            e.next = pc + 32'd4;
        else if (op == OP_JALR)
            e.next = (s1 + off) & 32'hFFFF_FFFE;
        else
            e.next = pc + off;
        e.mis = (e.next != pred);
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int fcnt;
        fcnt = q.size() - int'(m_ov);
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("occupancy", 64'(occupancy), 64'(fcnt));
        chk("in_ready", 64'(in_ready), 64'(fcnt < DEPTH));
        chk("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
        chk("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
        if (m_ov) begin
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            chk("out_wb", 64'(out_wb), 64'(q[0].wb));
            chk("out_link", 64'(out_link), 64'(q[0].link));
            chk("out_taken", 64'(out_taken), 64'(q[0].taken));
            chk("out_next_pc", 64'(out_next_pc), 64'(q[0].next));
            chk("out_mispredict", 64'(out_mispredict), 64'(q[0].mis));
        end
    endtask

    task automatic drive(bit v, logic [5:0] op, logic [31:0] s1, logic [31:0] s2, logic [31:0] pc,
                         logic [31:0] off, logic [31:0] pred, logic [3:0] tag);
        in_valid   = v;
        in_op      = op;
        in_src1    = s1;
        in_src2    = s2;
        in_pc      = pc;
        in_offset  = off;
        in_pred_pc = pred;
        in_tag     = tag;
    endtask

    task automatic drive_random(bit v);
        logic [5:0]  op;
        logic [31:0] s1, s2, pc, off, pred;
        exp_t        e;
        op  = ops[$urandom_range(0, 8)];
        s1  = $urandom;
        s2  = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
        pc  = $urandom;
        off = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
        e   = model_resolve(op, s1, s2, pc, off, 32'd0, 4'd0);
        pred = $urandom_range(0, 1) ? e.next : (($urandom_range(0, 1) != 0) ? pc + 32'd4 : $urandom);
        drive(v, op, s1, s2, pc, off, pred, 4'($urandom));
    endtask

    // One clock: predict handshakes from model state, advance the model at the edge, check at negedge.
    task automatic tick();
        int   fcnt;
        bit   push;
        bit   cons;
        exp_t e;
        fcnt = q.size() - int'(m_ov);
        push = in_valid && (fcnt < DEPTH) && !flush;
        cons = m_ov && out_ready;
        e = model_resolve(in_op, in_src1, in_src2, in_pc, in_offset, in_pred_pc, in_tag);
        @(posedge clk);
        if (cons) begin
            m_bcnt++;
            if (q[0].mis) m_mcnt++;
        end
        if (flush) begin
            q.delete();
            m_ov = 0;
        end else begin
            if (cons) void'(q.pop_front());
            if (push) q.push_back(e);
            if (fcnt > 0 && (!m_ov || cons)) m_ov = 1;
            else if (cons) m_ov = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(0, 6'd0, 0, 0, 0, 0, 0, 0);
        q.delete();
        m_ov = 0;
        m_bcnt = 0;
        m_mcnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_next_pc", 64'(out_next_pc), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check_all();

        // BEQ taken against a fall-through prediction
        drive(1, OP_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 32'h104, 4'd1);
        tick();
        in_valid = 0;
        tick();
        chk("beq_valid", 64'(out_valid), 64'd1);
        chk("beq_taken", 64'(out_taken), 64'd1);
        chk("beq_next", 64'(out_next_pc), 64'h120);
        chk("beq_mis", 64'(out_mispredict), 64'd1);
        chk("beq_wb", 64'(out_wb), 64'd0);
        out_ready = 1;
        tick();
        chk("beq_mcnt", 64'(mispredict_cnt), 64'd1);

        // JALR clears bit 0 of the target and writes the link
        drive(1, OP_JALR, 32'h1003, 32'd0, 32'h200, 32'd4, 32'h1006, 4'd3);
        tick();
        in_valid = 0;
        tick();
        chk("jalr_next", 64'(out_next_pc), 64'h1006);
        chk("jalr_link", 64'(out_link), 64'h204);
        chk("jalr_wb", 64'(out_wb), 64'd1);
        chk("jalr_mis", 64'(out_mispredict), 64'd0);
        chk("jalr_tag", 64'(out_tag), 64'd3);

        // Signed vs unsigned compare on the same operands, in issue order
        drive(1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'd8, 32'h44, 4'd5);
        tick();
        drive(1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'd8, 32'h44, 4'd6);
        tick();
        in_valid = 0;
        chk("blt_next", 64'(out_next_pc), 64'h48);
        chk("blt_taken", 64'(out_taken), 64'd1);
        chk("blt_tag", 64'(out_tag), 64'd5);
        tick();
        chk("bltu_next", 64'(out_next_pc), 64'h44);
        chk("bltu_taken", 64'(out_taken), 64'd0);
        chk("bltu_tag", 64'(out_tag), 64'd6);
        tick();

        // Backpressure: DEPTH in the FIFO plus one held at the output
        out_ready = 0;
        for (int i = 0; i < 7; i++) begin
            drive_random(1);
            tick();
        end
        chk("bp_occupancy", 64'(occupancy), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        in_valid = 0;
        out_ready = 1;
        repeat (6) tick();

        // Flush with a concurrent offer: everything dropped
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive_random(1);
            tick();
        end
        chk("pre_flush_occupancy", 64'(occupancy), 64'd3);
        drive_random(1);
        flush = 1;
        tick();
        flush = 0;
        in_valid = 0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        out_ready = 1;
        repeat (2) tick();

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive_random($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 0;

        // Asynchronous reset between edges, mid-stream
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive_random(1);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_branch_cnt", 64'(branch_cnt), 64'd0);
        chk("arst_mispredict_cnt", 64'(mispredict_cnt), 64'd0);
        chk("arst_next_pc", 64'(out_next_pc), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        q.delete();
        m_ov = 0;
        m_bcnt = 0;
        m_mcnt = 0;
        in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            drive_random(1);
            tick();
        end
        in_valid = 0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
